// File: rtl/pipe_stage_buf.sv
// Parametrised inter-stage pipeline register with valid/ready handshake,
// stall, flush and bubble support, and an optional 2-entry skid buffer.
module pipe_stage_buf #(
  parameter int                CTRL_W  = 9,
  parameter int                DATA_W  = 148,
  parameter bit                SKID    = 1'b1,
  parameter logic [DATA_W-1:0] RST_VAL = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic              bubble,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [CTRL_W-1:0] main_ctrl;
  logic [DATA_W-1:0] main_data;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] skid_data;
  logic [CTRL_W-1:0] ctrl_eff;
  logic              in_xfer;
  logic              out_xfer;
  logic              load_main;
  logic              load_skid;
  logic              skid_to_main;

  assign ctrl_eff  = bubble ? '0 : in_ctrl;
  assign out_valid = (state != EMPTY);
  assign in_xfer   = in_valid & in_ready;
  assign out_xfer  = out_valid & out_ready;
  assign out_ctrl  = out_valid ? main_ctrl : '0;
  assign out_data  = main_data;

  always_comb begin
    occupancy = 2'd0;
    case (state)
      ONE:     occupancy = 2'd1;
      FULL:    occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  end

  // With the skid entry, in_ready comes straight from a flop that predicts
  // whether the skid slot will be free; without it we fall back to the
  // legacy combinational rule through out_ready.
  generate
    if (SKID) begin : g_skid
      logic ready_q;
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          ready_q <= 1'b1;
        end else begin
          ready_q <= (state_next != FULL);
        end
      end
      assign in_ready = ready_q;
    end else begin : g_single
      assign in_ready = (state == EMPTY) | out_ready;
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= EMPTY;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next   = state;
    load_main    = 1'b0;
    load_skid    = 1'b0;
    skid_to_main = 1'b0;
    if (flush) begin
      state_next = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (in_xfer) begin
            state_next = ONE;
            load_main  = 1'b1;
          end
        end
        ONE: begin
          if (in_xfer && out_xfer) begin
            load_main = 1'b1;
          end else if (in_xfer) begin
            state_next = FULL;
            load_skid  = 1'b1;
          end else if (out_xfer) begin
            state_next = EMPTY;
          end
        end
        FULL: begin
          if (out_xfer) begin
            state_next   = ONE;
            skid_to_main = 1'b1;
          end
        end
        default: state_next = EMPTY;
      endcase
    end
  end

  // Main data is left untouched on a plain drain so out_data holds its value.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      main_ctrl <= '0;
      main_data <= RST_VAL;
      skid_ctrl <= '0;
      skid_data <= RST_VAL;
    end else if (flush) begin
      main_ctrl <= '0;
      main_data <= RST_VAL;
      skid_ctrl <= '0;
      skid_data <= RST_VAL;
    end else begin
      if (load_main) begin
        main_ctrl <= ctrl_eff;
        main_data <= in_data;
      end else if (skid_to_main) begin
        main_ctrl <= skid_ctrl;
        main_data <= skid_data;
      end
      if (load_skid) begin
        skid_ctrl <= ctrl_eff;
        skid_data <= in_data;
      end
    end
  end

endmodule
